// File: rtl/instr_sequencer_if.sv
// Instruction-memory read port and CPU control port seen by the instruction sequencer.
// The sequencer is the master: it drives the memory address and the CPU strobes.
interface instr_sequencer_if #(
    parameter int ADDR_W = 8
);
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_rdata;
    logic [15:0]       cpu_in;
    logic              cpu_load;
    logic              cpu_s;
    logic              cpu_w;

    modport master (
        output mem_addr,
        input  mem_rdata,
        output cpu_in,
        output cpu_load,
        output cpu_s,
        input  cpu_w
    );

    modport slave (
        input  mem_addr,
        output mem_rdata,
        input  cpu_in,
        input  cpu_load,
        input  cpu_s,
        output cpu_w
    );
endinterface

// File: rtl/instr_sequencer.sv
// Steps a CPU through a program held in synchronous instruction memory:
// fetch, load the instruction register, start the CPU, wait for it to finish, retire.
module instr_sequencer #(
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [ADDR_W-1:0]  prog_len,
    instr_sequencer_if.master  bus,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [ADDR_W-1:0]  pc,
    output logic [2:0]         fsm_state
);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] FETCH  = 3'd1;
    localparam logic [2:0] LOAD   = 3'd2;
    localparam logic [2:0] START  = 3'd3;
    localparam logic [2:0] RUN    = 3'd4;
    localparam logic [2:0] RETIRE = 3'd5;
    localparam logic [2:0] FIN    = 3'd6;

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [2:0]        state;
    logic [ADDR_W-1:0] len;
    logic [CNT_W-1:0]  cnt;
    logic              fell;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       cpu_in;
    logic              cpu_load;
    logic              cpu_s;

    assign bus.mem_addr = mem_addr;
    assign bus.cpu_in   = cpu_in;
    assign bus.cpu_load = cpu_load;
    assign bus.cpu_s    = cpu_s;
    assign fsm_state    = state;

    // Every output is a flop; done is raised on the edge that enters FIN so it
    // is visible exactly for the FIN cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            len      <= '0;
            cnt      <= '0;
            fell     <= 1'b0;
            pc       <= '0;
            mem_addr <= '0;
            cpu_in   <= '0;
            cpu_load <= 1'b0;
            cpu_s    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            cpu_load <= 1'b0;
            cpu_s    <= 1'b0;
            done     <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        len      <= prog_len;
                        pc       <= '0;
                        mem_addr <= '0;
                        err      <= 1'b0;
                        busy     <= 1'b1;
                        if (prog_len == '0) begin
                            done  <= 1'b1;
                            state <= FIN;
                        end else begin
                            state <= FETCH;
                        end
                    end
                end
                FETCH: state <= LOAD;
                LOAD: begin
                    cpu_in   <= bus.mem_rdata;
                    cpu_load <= 1'b1;
                    state    <= START;
                end
                START: begin
                    if (bus.cpu_w) begin
                        cpu_s <= 1'b1;
                        cnt   <= '0;
                        fell  <= 1'b0;
                        state <= RUN;
                    end else begin
                        err   <= 1'b1;
                        done  <= 1'b1;
                        state <= FIN;
                    end
                end
                RUN: begin
                    // Completion needs a fall then a rise of cpu_w; it wins over a
                    // timeout landing in the same cycle.
                    if (!bus.cpu_w) fell <= 1'b1;
                    if (fell && bus.cpu_w) begin
                        state <= RETIRE;
                    end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                        err   <= 1'b1;
                        done  <= 1'b1;
                        state <= FIN;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RETIRE: begin
                    if (pc == len - 1'b1) begin
                        done  <= 1'b1;
                        state <= FIN;
                    end else begin
                        pc       <= pc + 1'b1;
                        mem_addr <= pc + 1'b1;
                        state    <= FETCH;
                    end
                end
                FIN: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: synchronous instruction memory, a small CPU model with
// normal / hang / stuck-busy behaviours, and a scoreboard of expected instruction words.
module tb_instr_sequencer;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  prog_len;
    logic        busy, done, err;
    logic [7:0]  pc;
    logic [2:0]  fsm_state;

    int checks = 0;
    int failures = 0;
    int cpu_mode = 0;   // 0 normal, 1 hang after cpu_s, 2 never idle

    logic [15:0] mem [0:255];
    logic [15:0] exp_q[$];
    logic [15:0] obs_q[$];
    logic [15:0] ir;
    int          exec_cnt;

    instr_sequencer_if #(.ADDR_W(8)) bus ();

    instr_sequencer #(.ADDR_W(8), .TIMEOUT(64)) dut (
        .clk(clk), .reset(reset), .start(start), .prog_len(prog_len),
        .bus(bus), .busy(busy), .done(done), .err(err), .pc(pc), .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) bus.mem_rdata <= mem[bus.mem_addr];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.cpu_w <= 1'b1;
            exec_cnt  <= 0;
            ir        <= '0;
        end else begin
            if (bus.cpu_load) ir <= bus.cpu_in;
            if (cpu_mode == 2) begin
                bus.cpu_w <= 1'b0;
            end else if (bus.cpu_s && bus.cpu_w) begin
                bus.cpu_w <= 1'b0;
                exec_cnt  <= 32'(ir[1:0]) + 2;
            end else if (!bus.cpu_w && cpu_mode == 0) begin
                if (exec_cnt == 0) bus.cpu_w <= 1'b1;
                else exec_cnt <= exec_cnt - 1;
            end
        end
    end

    task automatic pulse_start(input logic [7:0] len);
        @(negedge clk);
        start = 1'b1;
        prog_len = len;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Observes the DUT at negedges until done plus a short tail; optionally re-pulses start.
    task automatic collect(input int budget, input int repulse_at,
                           output int n_load, output int n_s, output int n_done,
                           output int n_overlap, output logic err_d,
                           output logic [7:0] pc_d, output bit expired);
        int stop_at = -1;
        obs_q.delete();
        n_load = 0; n_s = 0; n_done = 0; n_overlap = 0;
        err_d = 1'bx; pc_d = 'x; expired = 1'b1;
        for (int i = 0; i < budget; i++) begin
            if (bus.cpu_load) begin
                n_load++;
                obs_q.push_back(bus.cpu_in);
            end
            if (bus.cpu_s) n_s++;
            if (bus.cpu_load && bus.cpu_s) n_overlap++;
            if (done) begin
                n_done++;
                if (n_done == 1) begin
                    err_d = err;
                    pc_d = pc;
                    stop_at = i + 4;
                end
            end
            if (i == stop_at) begin
                expired = 1'b0;
                break;
            end
            if (i == repulse_at) begin
                start = 1'b1;
                prog_len = 8'd1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; prog_len = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({pc, bus.mem_addr, bus.cpu_in, bus.cpu_load, bus.cpu_s, busy, done, err} !== '0) begin
            failures++;
            $display("FAIL reset_outputs pc=%h addr=%h in=%h ld=%b s=%b busy=%b done=%b err=%b expected all 0",
                     pc, bus.mem_addr, bus.cpu_in, bus.cpu_load, bus.cpu_s, busy, done, err);
        end
        checks++;
        if (fsm_state !== 3'd0) begin
            failures++;
            $display("FAIL reset_state got=%0d expected=0", fsm_state);
        end
    endtask

    task automatic test_program();
        int nl, ns, nd, no;
        logic e;
        logic [7:0] p;
        bit x;
        logic [15:0] ew, ow;
        mem[0] = 16'hD007; mem[1] = 16'hD108; mem[2] = 16'hA041;
        for (int i = 0; i < 3; i++) exp_q.push_back(mem[i]);
        pulse_start(8'd3);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL prog_busy got=%b expected=1", busy);
        end
        collect(600, -1, nl, ns, nd, no, e, p, x);
        checks++;
        if (x || nd != 1) begin
            failures++;
            $display("FAIL prog_done_count got=%0d expired=%0d expected=1", nd, x);
        end
        checks++;
        if (nl != 3 || ns != 3) begin
            failures++;
            $display("FAIL prog_strobes loads=%0d starts=%0d expected=3/3", nl, ns);
        end
        while (exp_q.size() > 0) begin
            ew = exp_q.pop_front();
            ow = (obs_q.size() > 0) ? obs_q.pop_front() : 16'hxxxx;
            checks++;
            if (ow !== ew) begin
                failures++;
                $display("FAIL prog_cpu_in got=%h expected=%h", ow, ew);
            end
        end
        checks++;
        if (e !== 1'b0 || p !== 8'd2) begin
            failures++;
            $display("FAIL prog_final err=%b pc=%0d expected err=0 pc=2", e, p);
        end
        checks++;
        if (no != 0) begin
            failures++;
            $display("FAIL prog_overlap got=%0d expected=0", no);
        end
        checks++;
        if (busy !== 1'b0 || fsm_state !== 3'd0) begin
            failures++;
            $display("FAIL prog_idle busy=%b state=%0d expected 0/0", busy, fsm_state);
        end
    endtask

    task automatic test_zero_len();
        int nl, ns, nd, no;
        logic e;
        logic [7:0] p;
        bit x;
        pulse_start(8'd0);
        checks++;
        if (done !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL zero_done_latency done=%b busy=%b expected 1/1", done, busy);
        end
        collect(20, -1, nl, ns, nd, no, e, p, x);
        checks++;
        if (x || nd != 1 || nl != 0 || ns != 0 || e !== 1'b0) begin
            failures++;
            $display("FAIL zero_len done=%0d loads=%0d starts=%0d err=%b expected 1/0/0/0", nd, nl, ns, e);
        end
    endtask

    task automatic test_timeout();
        int k = -1;
        int nl, ns, nd, no;
        logic e;
        logic [7:0] p;
        bit x;
        cpu_mode = 1;
        mem[0] = 16'h1234; mem[1] = 16'h5678;
        pulse_start(8'd2);
        for (int i = 0; i < 20; i++) begin
            if (bus.cpu_s) begin
                k = 0;
                break;
            end
            @(negedge clk);
        end
        if (k == 0) begin
            for (int i = 0; i < 200; i++) begin
                if (done) break;
                @(negedge clk);
                k++;
            end
        end
        checks++;
        if (k != 64 || err !== 1'b1) begin
            failures++;
            $display("FAIL timeout_latency cycles=%0d err=%b expected 64/1", k, err);
        end
        @(negedge clk);
        cpu_mode = 0;
        repeat (3) @(negedge clk);
        checks++;
        if (err !== 1'b1) begin
            failures++;
            $display("FAIL timeout_sticky err=%b expected=1", err);
        end
        pulse_start(8'd1);
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL timeout_err_clear err=%b expected=0", err);
        end
        collect(200, -1, nl, ns, nd, no, e, p, x);
        checks++;
        if (x || nd != 1 || e !== 1'b0) begin
            failures++;
            $display("FAIL timeout_recover done=%0d err=%b expected 1/0", nd, e);
        end
    endtask

    task automatic test_not_idle();
        int nl, ns, nd, no;
        logic e;
        logic [7:0] p;
        bit x;
        cpu_mode = 2;
        mem[0] = 16'hBEEF;
        @(negedge clk);
        pulse_start(8'd2);
        collect(100, -1, nl, ns, nd, no, e, p, x);
        checks++;
        if (x || nd != 1 || ns != 0 || e !== 1'b1) begin
            failures++;
            $display("FAIL not_idle done=%0d starts=%0d err=%b expected 1/0/1", nd, ns, e);
        end
        cpu_mode = 0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_mid_run();
        int seen = 0;
        int nl, ns, nd, no;
        logic e;
        logic [7:0] p;
        bit x;
        logic [15:0] ew, ow;
        mem[0] = 16'h1111; mem[1] = 16'h2222; mem[2] = 16'h3333;
        pulse_start(8'd3);
        for (int i = 0; i < 200; i++) begin
            if (bus.cpu_s) seen++;
            if (seen == 2) break;
            @(negedge clk);
        end
        checks++;
        if (seen != 2 || pc !== 8'd1) begin
            failures++;
            $display("FAIL rst_reach_instr2 starts=%0d pc=%0d expected 2/1", seen, pc);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({pc, bus.mem_addr, bus.cpu_in, bus.cpu_load, bus.cpu_s, busy, done, err, fsm_state} !== '0) begin
            failures++;
            $display("FAIL rst_async pc=%h addr=%h in=%h ld=%b s=%b busy=%b done=%b err=%b st=%0d expected all 0",
                     pc, bus.mem_addr, bus.cpu_in, bus.cpu_load, bus.cpu_s, busy, done, err, fsm_state);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL rst_no_done done=%b expected=0", done);
        end
        for (int i = 0; i < 3; i++) exp_q.push_back(mem[i]);
        pulse_start(8'd3);
        checks++;
        if (fsm_state !== 3'd1 || bus.mem_addr !== 8'd0) begin
            failures++;
            $display("FAIL rst_restart_fetch state=%0d addr=%0d expected 1/0", fsm_state, bus.mem_addr);
        end
        collect(600, -1, nl, ns, nd, no, e, p, x);
        checks++;
        if (x || nd != 1 || nl != 3) begin
            failures++;
            $display("FAIL rst_restart_run done=%0d loads=%0d expected 1/3", nd, nl);
        end
        while (exp_q.size() > 0) begin
            ew = exp_q.pop_front();
            ow = (obs_q.size() > 0) ? obs_q.pop_front() : 16'hxxxx;
            checks++;
            if (ow !== ew) begin
                failures++;
                $display("FAIL rst_cpu_in got=%h expected=%h", ow, ew);
            end
        end
    endtask

    task automatic test_back_to_back();
        int nl, ns, nd, no;
        logic e;
        logic [7:0] p;
        bit x;
        logic [15:0] ew, ow;
        for (int i = 0; i < 4; i++) begin
            mem[i] = 16'($urandom_range(0, 16'hFFFF));
            exp_q.push_back(mem[i]);
        end
        pulse_start(8'd4);
        collect(800, $urandom_range(3, 12), nl, ns, nd, no, e, p, x);
        checks++;
        if (x || nd != 1 || nl != 4 || e !== 1'b0 || p !== 8'd3) begin
            failures++;
            $display("FAIL busy_restart done=%0d loads=%0d err=%b pc=%0d expected 1/4/0/3", nd, nl, e, p);
        end
        while (exp_q.size() > 0) begin
            ew = exp_q.pop_front();
            ow = (obs_q.size() > 0) ? obs_q.pop_front() : 16'hxxxx;
            checks++;
            if (ow !== ew) begin
                failures++;
                $display("FAIL busy_cpu_in got=%h expected=%h", ow, ew);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        test_reset();
        test_program();
        test_zero_len();
        test_timeout();
        test_not_idle();
        test_reset_mid_run();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
